// File: rtl/rom_stream_reader.sv
// Burst reader: streams consecutive words from a combinational ROM into a 2-entry output FIFO.
// Optional feature: define ROM_READER_CHECKSUM_EN to add the per-burst XOR checksum output.
module rom_stream_reader #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 64,
   parameter int LEN_WIDTH     = 7
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]     length,
   output logic [ADDRESS_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0]    rom_data,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     done,
   output logic                     err
`ifdef ROM_READER_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0]    checksum
`endif
);

   localparam int AW1 = ADDRESS_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      DONE
   } state_t;

   state_t                   state;
   logic [ADDRESS_WIDTH-1:0] addr;
   logic [LEN_WIDTH-1:0]     remaining;
   logic [DATA_WIDTH-1:0]    q0;
   logic [DATA_WIDTH-1:0]    q1;
   logic [1:0]               count;
   logic                     pop;
   logic                     push;
   logic                     bad_req;
   logic [AW1-1:0]           end_addr;

   // One bit wider than the address so a large base cannot wrap past DEPTH.
   assign end_addr = {1'b0, base_addr} + AW1'(length);
   assign bad_req  = (length == '0) || (end_addr > AW1'(DEPTH));

   assign pop  = (count != 2'd0) && out_ready;
   assign push = (state == FETCH) && ((count != 2'd2) || pop);

   assign rom_addr  = addr;
   assign out_data  = q0;
   assign out_valid = (count != 2'd0);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         q0        <= '0;
         q1        <= '0;
         count     <= 2'd0;
         done      <= 1'b0;
         err       <= 1'b0;
`ifdef ROM_READER_CHECKSUM_EN
         checksum  <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;

         // q0 is always the head; a pop shifts q1 forward.
         if (push && pop) begin
            if (count == 2'd1) begin
               q0 <= rom_data;
            end else begin
               q0 <= q1;
               q1 <= rom_data;
            end
         end else if (push) begin
            if (count == 2'd0) begin
               q0 <= rom_data;
            end else begin
               q1 <= rom_data;
            end
            count <= count + 2'd1;
         end else if (pop) begin
            q0    <= q1;
            count <= count - 2'd1;
         end

         unique case (state)
            IDLE: begin
               if (start) begin
                  if (bad_req) begin
                     err <= 1'b1;
                  end else begin
                     addr      <= base_addr;
                     remaining <= length;
                     state     <= FETCH;
`ifdef ROM_READER_CHECKSUM_EN
                     checksum  <= '0;
`endif
                  end
               end
            end
            FETCH: begin
               if (push) begin
                  addr      <= addr + 1'b1;
                  remaining <= remaining - 1'b1;
`ifdef ROM_READER_CHECKSUM_EN
                  checksum  <= checksum ^ rom_data;
`endif
                  if (remaining == LEN_WIDTH'(1)) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (count == 2'd0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader; ROM model returns 0x100+addr.
// Define ROM_READER_CHECKSUM_EN to also check the checksum output.
module tb_rom_stream_reader;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 64;
   localparam int LW    = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [LW-1:0] length = '0;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy;
   logic          done;
   logic          err;
`ifdef ROM_READER_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   rom_stream_reader #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH(DW),
      .DEPTH(DEPTH),
      .LEN_WIDTH(LW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .base_addr(base_addr),
      .length(length),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy(busy),
      .done(done),
      .err(err)
`ifdef ROM_READER_CHECKSUM_EN
      ,
      .checksum(checksum)
`endif
   );

   assign rom_data = 32'h100 + rom_addr;

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int valid_cnt = 0;
   logic [DW-1:0] got[$];
   int stamp[$];

   always @(posedge clk) cyc++;

   // Inputs change 1ns after posedge, so the negedge view is what the next edge uses.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         got.push_back(out_data);
         stamp.push_back(cyc);
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (out_valid) valid_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got.delete();
      stamp.delete();
      done_cnt = 0;
      err_cnt = 0;
      valid_cnt = 0;
   endtask

   task automatic issue(input logic [AW-1:0] b, input int l);
      start = 1'b1;
      base_addr = b;
      length = LW'(l);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      for (int i = 0; i < budget && busy; i++) tick();
      ok = !busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: valid=%b busy=%b done=%b err=%b required all 0",
                  out_valid, busy, done, err);
      end
      n_checks++;
      if (rom_addr !== '0 || out_data !== '0) begin
         n_fail++;
         $display("FAIL reset_buses: rom_addr=%h out_data=%h required 0", rom_addr, out_data);
      end
`ifdef ROM_READER_CHECKSUM_EN
      n_checks++;
      if (checksum !== '0) begin
         n_fail++;
         $display("FAIL reset_checksum: got %h required 0", checksum);
      end
`endif
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_basic();
      bit ok;
      clear_mon();
      out_ready = 1'b1;
      issue(0, 4);
      n_checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || rom_addr !== 32'd0) begin
         n_fail++;
         $display("FAIL basic_fetch_entry: busy=%b valid=%b rom_addr=%0d required 1 0 0",
                  busy, out_valid, rom_addr);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h100) begin
         n_fail++;
         $display("FAIL basic_latency: valid=%b data=%h required 1 100", out_valid, out_data);
      end
      wait_idle(50, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL basic_timeout: busy=%b required 0", busy);
      end
      n_checks++;
      if (got.size() != 4) begin
         n_fail++;
         $display("FAIL basic_count: got %0d words required 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got[i] !== DW'(32'h100 + i) || stamp[i] != stamp[0] + i) begin
               n_fail++;
               $display("FAIL basic_word%0d: got %h at +%0d required %h at +%0d",
                        i, got[i], stamp[i] - stamp[0], 32'h100 + i, i);
            end
         end
      end
      n_checks++;
      if (done_cnt != 1) begin
         n_fail++;
         $display("FAIL basic_done: pulses %0d required 1", done_cnt);
      end
`ifdef ROM_READER_CHECKSUM_EN
      n_checks++;
      if (checksum !== 32'h0) begin
         n_fail++;
         $display("FAIL basic_checksum: got %h required 0", checksum);
      end
`endif
   endtask

   task automatic test_backpressure();
      bit ok;
      clear_mon();
      out_ready = 1'b0;
      issue(10, 3);
      repeat (5) tick();
      n_checks++;
      if (rom_addr !== 32'd12 || out_valid !== 1'b1 || out_data !== 32'h10A) begin
         n_fail++;
         $display("FAIL bp_stall: rom_addr=%0d valid=%b data=%h required 12 1 10a",
                  rom_addr, out_valid, out_data);
      end
      n_checks++;
      if (got.size() != 0) begin
         n_fail++;
         $display("FAIL bp_no_transfer: got %0d words required 0", got.size());
      end
      out_ready = 1'b1;
      wait_idle(50, ok);
      n_checks++;
      if (!ok || got.size() != 3) begin
         n_fail++;
         $display("FAIL bp_count: idle=%b words=%0d required 1 3", ok, got.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got[i] !== DW'(32'h10A + i)) begin
               n_fail++;
               $display("FAIL bp_word%0d: got %h required %h", i, got[i], 32'h10A + i);
            end
         end
      end
   endtask

   task automatic test_reject();
      clear_mon();
      out_ready = 1'b1;
      issue(62, 3);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rej_range: err=%b busy=%b required 1 0", err, busy);
      end
      tick();
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL rej_pulse_width: err=%b required 0", err);
      end
      repeat (2) tick();
      issue(0, 0);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rej_zero: err=%b busy=%b required 1 0", err, busy);
      end
      repeat (3) tick();
      n_checks++;
      if (err_cnt != 2 || valid_cnt != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rej_summary: errs=%0d valids=%0d busy=%b required 2 0 0",
                  err_cnt, valid_cnt, busy);
      end
   endtask

   task automatic test_boundary();
      bit ok;
      clear_mon();
      out_ready = 1'b1;
      issue(60, 4);
      wait_idle(50, ok);
      n_checks++;
      if (!ok || err_cnt != 0 || got.size() != 4) begin
         n_fail++;
         $display("FAIL edge_accept: idle=%b errs=%0d words=%0d required 1 0 4",
                  ok, err_cnt, got.size());
      end else begin
         n_checks++;
         if (got[3] !== 32'h13F || got[0] !== 32'h13C) begin
            n_fail++;
            $display("FAIL edge_words: first %h last %h required 13c 13f", got[0], got[3]);
         end
      end
   endtask

   task automatic test_ignore_start();
      bit ok;
      clear_mon();
      out_ready = 1'b1;
      issue(0, 8);
      repeat (2) tick();
      issue(5, 2);
      wait_idle(60, ok);
      n_checks++;
      if (!ok || got.size() != 8 || done_cnt != 1 || err_cnt != 0) begin
         n_fail++;
         $display("FAIL ign_summary: idle=%b words=%0d done=%0d errs=%0d required 1 8 1 0",
                  ok, got.size(), done_cnt, err_cnt);
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got[i] !== DW'(32'h100 + i)) begin
               n_fail++;
               $display("FAIL ign_word%0d: got %h required %h", i, got[i], 32'h100 + i);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int i;
      clear_mon();
      out_ready = 1'b1;
      issue(0, 6);
      i = 0;
      while (got.size() < 2 && i < 50) begin
         tick();
         i++;
      end
      n_checks++;
      if (got.size() < 2) begin
         n_fail++;
         $display("FAIL mrst_progress: words=%0d required 2", got.size());
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
          rom_addr !== '0 || out_data !== '0) begin
         n_fail++;
         $display("FAIL mrst_outputs: v=%b b=%b d=%b e=%b a=%h q=%h required all 0",
                  out_valid, busy, done, err, rom_addr, out_data);
      end
      tick();
      rst_n = 1'b1;
      clear_mon();
      repeat (10) tick();
      n_checks++;
      if (valid_cnt != 0 || busy !== 1'b0 || done_cnt != 0) begin
         n_fail++;
         $display("FAIL mrst_quiet: valids=%0d busy=%b done=%0d required 0 0 0",
                  valid_cnt, busy, done_cnt);
      end
   endtask

   task automatic test_random();
      int b;
      int l;
      bit good;
      int max_addr;
      int k;
      logic [DW-1:0] sum;
      for (int n = 0; n < 25; n++) begin
         b = $urandom_range(0, 66);
         l = $urandom_range(0, 12);
         good = (l != 0) && (b + l <= DEPTH);
         clear_mon();
         out_ready = 1'($urandom_range(0, 1));
         issue(AW'(b), l);
         max_addr = 0;
         k = 0;
         while (busy && k < 400) begin
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
         end
         out_ready = 1'b1;
         repeat (2) tick();
         n_checks++;
         if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd%0d_timeout: busy=%b required 0", n, busy);
         end else if (!good) begin
            n_checks++;
            if (err_cnt != 1 || got.size() != 0 || done_cnt != 0) begin
               n_fail++;
               $display("FAIL rnd%0d_reject b=%0d l=%0d: errs=%0d words=%0d required 1 0",
                        n, b, l, err_cnt, got.size());
            end
         end else begin
            n_checks++;
            if (got.size() != l || done_cnt != 1 || err_cnt != 0 || max_addr > b + l) begin
               n_fail++;
               $display("FAIL rnd%0d_burst b=%0d l=%0d: words=%0d done=%0d maxaddr=%0d",
                        n, b, l, got.size(), done_cnt, max_addr);
            end else begin
               sum = '0;
               for (int i = 0; i < l; i++) begin
                  sum = sum ^ DW'(32'h100 + b + i);
                  n_checks++;
                  if (got[i] !== DW'(32'h100 + b + i)) begin
                     n_fail++;
                     $display("FAIL rnd%0d_word%0d: got %h required %h",
                              n, i, got[i], 32'h100 + b + i);
                  end
               end
`ifdef ROM_READER_CHECKSUM_EN
               n_checks++;
               if (checksum !== sum) begin
                  n_fail++;
                  $display("FAIL rnd%0d_checksum: got %h required %h", n, checksum, sum);
               end
`endif
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_reject();
      test_boundary();
      test_ignore_start();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
